// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the core MEM stage and a word-wide 1-cycle-latency SRAM.
//   Word stores take one cycle. Byte/half stores use a read-modify-write. Loads right-justify the lane.
//   Ports: clk, rst_n (async, active low); req_re/req_we/req_addr/req_wdata/req_size from the core;
//   core_rdata/stall to the core; sram_ce/sram_we/sram_addr/sram_wdata to the SRAM, sram_rdata from it.
//   Optional macro DMEM_MISALIGN_CHECK_EN adds output misalign_err and suppresses misaligned accesses.
module dmem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_re,
  input  logic                  req_we,
  input  logic [BUS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_size,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  stall,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic                  misalign_err
`endif
);
  typedef enum logic [1:0] {IDLE, LD_RESP, ST_MERGE} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d, a;
  logic [1:0] size_q, size_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic is_byte, is_half, is_word, mis, req, go, wr_word, lb, lh;
  logic [4:0] sh;
  logic [DATA_WIDTH-1:0] ld_data, lane_mask, merged;
  logic unused_bits;
  // Upper address bits alias (SRAM wraps); funct3[2] only selects extension, done in WB.
  assign unused_bits = ^{req_addr[BUS_WIDTH-1:ADDR_WIDTH+2], req_size[2]};
  assign a = req_addr[ADDR_WIDTH+1:0];
  assign is_byte = req_size[1:0] == 2'b00;
  assign is_half = req_size[1:0] == 2'b01;
  assign is_word = !is_byte && !is_half;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis = (is_half && a[0]) || (is_word && a[1:0] != 2'b00);
  assign misalign_err = req && mis;
`else
  assign mis = 1'b0;
`endif
  // rst_n gates acceptance so nothing reaches the SRAM while reset is held.
  assign req = rst_n && state_q == IDLE && (req_re || req_we);
  assign go = req && !mis;
  assign wr_word = go && req_we && is_word;
  assign lb = size_q == 2'b00;
  assign lh = size_q == 2'b01;
  // Word accesses ignore addr[1:0]; halves pick the lane by addr[1] only.
  assign sh = lb ? {addr_q[1:0], 3'b000} : lh ? {addr_q[1], 4'b0000} : 5'd0;
  assign ld_data = sram_rdata >> sh;
  assign lane_mask = (lb ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << sh;
  assign merged = (sram_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  assign addr_d = go ? a : addr_q;
  assign size_d = go ? req_size[1:0] : size_q;
  assign wdata_d = go && req_we ? req_wdata : wdata_q;
  assign rdata_d = state_q == LD_RESP ? ld_data : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // Stores win over a simultaneous load; requests are only accepted in IDLE.
  always_comb begin
    state_d = !go ? IDLE : req_we ? (is_word ? IDLE : ST_MERGE) : LD_RESP;
  end
  always_comb begin
    sram_ce = go || state_q == ST_MERGE;
    sram_we = wr_word || state_q == ST_MERGE;
    sram_addr = state_q == ST_MERGE ? addr_q[ADDR_WIDTH+1:2] : go ? a[ADDR_WIDTH+1:2] : '0;
    sram_wdata = state_q == ST_MERGE ? merged : wr_word ? req_wdata : '0;
    stall = go && !wr_word;
    core_rdata = state_q == LD_RESP ? ld_data : rdata_q;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed table-driven bench for dmem_ctrl with a behavioural 1-cycle SRAM.
module tb_dmem_ctrl;
  typedef logic [78:0] obs_t;
  typedef struct {
    logic re;
    logic we;
    logic [2:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    obs_t exp;
  } vec_t;
  localparam int NV = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic req_re, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0] req_size;
  logic [31:0] core_rdata;
  logic stall, sram_ce, sram_we;
  logic [11:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic misalign_err;
`endif
  logic [31:0] mem [0:4095];
  vec_t v [NV];
  int n_vec = 0;
  int n_err = 0;

  dmem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_re(req_re), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .core_rdata(core_rdata), .stall(stall),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
`ifdef DMEM_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_ce && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
  end

  function automatic obs_t ex(logic ce, logic we, logic [11:0] ad, logic [31:0] wd, logic st, logic [31:0] rd);
    return {ce, we, ad, wd, st, rd};
  endfunction

  function automatic obs_t got();
    return {sram_ce, sram_we, sram_addr, sram_wdata, stall, core_rdata};
  endfunction

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (ce,we,addr,wdata,stall,rdata)", nm, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    req_re = re;
    req_we = we;
    req_size = sz;
    req_addr = ad;
    req_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0]  = '{1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h0)};
    v[1]  = '{1'b0, 1'b1, 3'd2, 32'h10,       32'h11223344, ex(1'b1, 1'b1, 12'd4, 32'h11223344, 1'b0, 32'h0)};
    v[2]  = '{1'b0, 1'b1, 3'd2, 32'h14,       32'h55667788, ex(1'b1, 1'b1, 12'd5, 32'h55667788, 1'b0, 32'h0)};
    v[3]  = '{1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h0)};
    v[4]  = '{1'b0, 1'b1, 3'd2, 32'h10,       32'hDEADBEEF, ex(1'b1, 1'b1, 12'd4, 32'hDEADBEEF, 1'b0, 32'h0)};
    v[5]  = '{1'b0, 1'b1, 3'd2, 32'h10,       32'h11223344, ex(1'b1, 1'b1, 12'd4, 32'h11223344, 1'b0, 32'h0)};
    v[6]  = '{1'b1, 1'b0, 3'd5, 32'h12,       32'h0,        ex(1'b1, 1'b0, 12'd4, 32'h0,        1'b1, 32'h0)};
    v[7]  = '{1'b1, 1'b0, 3'd5, 32'h12,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h00001122)};
    v[8]  = '{1'b0, 1'b0, 3'd0, 32'h0,        32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h00001122)};
    v[9]  = '{1'b0, 1'b1, 3'd0, 32'h12,       32'h000000AB, ex(1'b1, 1'b0, 12'd4, 32'h0,        1'b1, 32'h00001122)};
    v[10] = '{1'b0, 1'b1, 3'd0, 32'h12,       32'h000000AB, ex(1'b1, 1'b1, 12'd4, 32'h11AB3344, 1'b0, 32'h00001122)};
    v[11] = '{1'b0, 1'b1, 3'd2, 32'h10,       32'h11223344, ex(1'b1, 1'b1, 12'd4, 32'h11223344, 1'b0, 32'h00001122)};
    v[12] = '{1'b0, 1'b1, 3'd0, 32'h13,       32'hABCDEFFF, ex(1'b1, 1'b0, 12'd4, 32'h0,        1'b1, 32'h00001122)};
    v[13] = '{1'b0, 1'b1, 3'd0, 32'h13,       32'hABCDEFFF, ex(1'b1, 1'b1, 12'd4, 32'hFF223344, 1'b0, 32'h00001122)};
    v[14] = '{1'b1, 1'b0, 3'd2, 32'h10,       32'h0,        ex(1'b1, 1'b0, 12'd4, 32'h0,        1'b1, 32'h00001122)};
    v[15] = '{1'b1, 1'b0, 3'd2, 32'h10,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'hFF223344)};
    v[16] = '{1'b0, 1'b1, 3'd1, 32'h16,       32'h1234BEEF, ex(1'b1, 1'b0, 12'd5, 32'h0,        1'b1, 32'hFF223344)};
    v[17] = '{1'b0, 1'b1, 3'd1, 32'h16,       32'h1234BEEF, ex(1'b1, 1'b1, 12'd5, 32'hBEEF7788, 1'b0, 32'hFF223344)};
    v[18] = '{1'b1, 1'b0, 3'd0, 32'h15,       32'h0,        ex(1'b1, 1'b0, 12'd5, 32'h0,        1'b1, 32'hFF223344)};
    v[19] = '{1'b1, 1'b0, 3'd0, 32'h15,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h00BEEF77)};
    v[20] = '{1'b1, 1'b1, 3'd2, 32'h14,       32'h01020304, ex(1'b1, 1'b1, 12'd5, 32'h01020304, 1'b0, 32'h00BEEF77)};
    v[21] = '{1'b1, 1'b0, 3'd4, 32'h14,       32'h0,        ex(1'b1, 1'b0, 12'd5, 32'h0,        1'b1, 32'h00BEEF77)};
    v[22] = '{1'b1, 1'b0, 3'd4, 32'h14,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h01020304)};
    v[23] = '{1'b0, 1'b1, 3'd3, 32'h18,       32'hCAFEF00D, ex(1'b1, 1'b1, 12'd6, 32'hCAFEF00D, 1'b0, 32'h01020304)};
    v[24] = '{1'b1, 1'b0, 3'd7, 32'h18,       32'h0,        ex(1'b1, 1'b0, 12'd6, 32'h0,        1'b1, 32'h01020304)};
    v[25] = '{1'b1, 1'b0, 3'd7, 32'h18,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'hCAFEF00D)};
    v[26] = '{1'b1, 1'b0, 3'd2, 32'h4010,     32'h0,        ex(1'b1, 1'b0, 12'd4, 32'h0,        1'b1, 32'hCAFEF00D)};
    v[27] = '{1'b1, 1'b0, 3'd2, 32'h4010,     32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'hFF223344)};
    v[28] = '{1'b0, 1'b1, 3'd0, 32'hFFFF001B, 32'h0000005A, ex(1'b1, 1'b0, 12'd6, 32'h0,        1'b1, 32'hFF223344)};
    v[29] = '{1'b0, 1'b1, 3'd0, 32'hFFFF001B, 32'h0000005A, ex(1'b1, 1'b1, 12'd6, 32'h5AFEF00D, 1'b0, 32'hFF223344)};
    v[30] = '{1'b1, 1'b0, 3'd5, 32'h1A,       32'h0,        ex(1'b1, 1'b0, 12'd6, 32'h0,        1'b1, 32'hFF223344)};
    v[31] = '{1'b1, 1'b0, 3'd5, 32'h1A,       32'h0,        ex(1'b0, 1'b0, 12'd0, 32'h0,        1'b0, 32'h00005AFE)};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) step();
    chk("reset_state", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(v[i].re, v[i].we, v[i].size, v[i].addr, v[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d", i), got(), v[i].exp);
      step();
    end

    // Reset asserted while in LD_RESP with the request still held.
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ld_resp", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0));
    step();
    chk("rst_held_ld", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0));
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0));
    step();

    // Reset asserted in ST_MERGE: the merged write must never reach the SRAM.
    drive(1'b0, 1'b1, 3'd0, 32'h10, 32'h00000077);
    @(negedge clk);
    chk("rmw_read_issue", got(), ex(1'b1, 1'b0, 12'd4, 32'h0, 1'b1, 32'h0));
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_in_st_merge", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0));
    step();
    drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("load_after_rst", got(), ex(1'b1, 1'b0, 12'd4, 32'h0, 1'b1, 32'h0));
    step();
    @(negedge clk);
    chk("mem_untouched", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'hFF223344));
    step();

`ifdef DMEM_MISALIGN_CHECK_EN
    drive(1'b1, 1'b0, 3'd2, 32'h11, 32'h0);
    @(negedge clk);
    chk("mis_word_out", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'hFF223344));
    chk("mis_word_err", {78'd0, misalign_err}, 79'd1);
    step();
    drive(1'b1, 1'b0, 3'd1, 32'h13, 32'h0);
    @(negedge clk);
    chk("mis_half_err", {78'd0, misalign_err}, 79'd1);
    step();
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis_err_clear", {78'd0, misalign_err}, 79'd0);
    chk("mis_idle_out", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'hFF223344));
    step();
`else
    drive(1'b1, 1'b0, 3'd2, 32'h11, 32'h0);
    @(negedge clk);
    chk("unal_word_rd", got(), ex(1'b1, 1'b0, 12'd4, 32'h0, 1'b1, 32'hFF223344));
    step();
    @(negedge clk);
    chk("unal_word_data", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'hFF223344));
    step();
    drive(1'b1, 1'b0, 3'd1, 32'h13, 32'h0);
    step();
    @(negedge clk);
    chk("unal_half_data", got(), ex(1'b0, 1'b0, 12'd0, 32'h0, 1'b0, 32'h0000FF22));
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's MEM stage.
- Accepts the core's byte-addressed load/store requests and drives a word-wide synchronous SRAM with a 1-cycle read latency.
- Performs read-modify-write for byte and halfword stores. Right-justifies load data; sign/zero extension remains in the core's WB stage.
- Asserts stall, routed to pc_gen hold and the pipeline registers, while a multi-cycle access is in progress.

Parameters:
DATA_WIDTH, 32, data word width (fixed 32; byte lanes assume 4 lanes)
BUS_WIDTH, 32, core byte-address width
ADDR_WIDTH, 12, SRAM word-address width; sram_addr = req_addr[ADDR_WIDTH+1:2]

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_re  input  1  load request (MEM stage)
req_we  input  1  store request (MEM stage)
req_addr  input  BUS_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-justified
req_size  input  3  funct3 of load/store (000 b, 001 h, 010 w, 100 bu, 101 hu)
core_rdata  output  DATA_WIDTH  right-justified load data
stall  output  1  core must hold MEM-stage request and upstream stages
sram_ce  output  1  SRAM chip enable
sram_we  output  1  SRAM write enable (whole word)
sram_addr  output  ADDR_WIDTH  SRAM word address
sram_wdata  output  DATA_WIDTH  SRAM write data
sram_rdata  input  DATA_WIDTH  SRAM read data, valid the cycle after a ce&!we access

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; latched addr/size/wdata=0; core_rdata=0; stall=0; sram_ce/sram_we/sram_addr/sram_wdata=0. Reset mid-access abandons the access; no SRAM write occurs after reset asserts.
- States: IDLE, LD_RESP, ST_MERGE.
- IDLE, no request: all sram_* outputs 0, stall=0.
- IDLE, req_we, size=010: sram_ce=1, sram_we=1, sram_addr=word addr, sram_wdata=req_wdata, stall=0. Completes in 1 cycle; stay in IDLE.
- IDLE, req_we, size 000/001: issue read (ce=1, we=0) and latch addr/size/wdata. stall=1. Next state ST_MERGE.
- ST_MERGE: merge the latched byte/half into sram_rdata at lane addr[1:0] (byte) or addr[1] (half). Drive ce=1, we=1 with the merged word. stall=0. Next state IDLE.
- IDLE, req_re (any size): issue read (ce=1, we=0), latch addr/size. stall=1. Next state LD_RESP.
- LD_RESP: core_rdata = sram_rdata shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half), or the unshifted word (word size). Upper bits beyond the access width are passed through as shifted; the core masks and extends them. stall=0. This value is also captured into the hold register. Next state IDLE.
- Outside LD_RESP, core_rdata = hold register (last load value).
- Latency:
  - word store: 1 cycle, no stall.
  - load: 2 cycles, stall high 1 cycle.
  - sub-word store: 2 cycles, stall high 1 cycle.
- While the state is not IDLE, req_* inputs are ignored. The core still presents the same held request during LD_RESP/ST_MERGE; it is not re-issued.
- Simultaneous req_re & req_we: store takes priority; the load is dropped.
- Unsupported req_size (011, 11x) on a store is treated as a word store; on a load it is treated as word.
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so the address aliases modulo SRAM size.
- Store followed immediately by a load to the same word returns the new data. The write completes before the read is issued, because requests are accepted only in IDLE.

Optional Feature:
- DMEM_MISALIGN_CHECK_EN defined:
  - A halfword access with addr[0]=1 or a word access with addr[1:0]!=0 performs no SRAM access and no stall.
  - Adds output misalign_err (1 bit, reset 0), which pulses high for exactly that IDLE cycle.
  - core_rdata is unchanged.
- Not defined: no misalign_err port. Low address bits below access alignment are ignored: the halfword lane is chosen by addr[1] only, and word accesses use addr[1:0]=00.

Test Plan:
- Reset: hold rst_n=0 mid-load (state LD_RESP) -> all outputs 0 immediately, state IDLE, no subsequent sram_we.
- Word store: addr=0x10, wdata=0xDEADBEEF, size=010 -> same cycle ce=1, we=1, sram_addr=4, sram_wdata=0xDEADBEEF, stall=0.
- Byte store RMW: mem[4]=0x11223344; store byte 0xAB to addr 0x12 -> cycle 1: read, stall=1; cycle 2: write 0x11AB3344, stall=0.
- Half load: mem[4]=0x11223344; load size=101 at addr 0x12 -> stall 1 cycle, then core_rdata=0x00001122, held afterwards.
- Back-to-back: byte store 0xFF to 0x13, then word load 0x10 -> load returns 0xFF223344 (prior 0x11223344). Stall sequence 1,0,1,0.
- With DMEM_MISALIGN_CHECK_EN: word load at 0x11 -> misalign_err=1 for 1 cycle, sram_ce=0, stall=0.
